// File: rtl/nw_crossbar_oh_buffered_pkg.sv
// Shared NW router types: flit format, default port count and select helpers.
package nw_crossbar_oh_buffered_pkg;

    localparam int FLIT_W    = 8;
    localparam int NW_PORTS  = 5;   // default router port count (N, E, S, W, local)
    localparam int SEL_MAX_W = 32;  // widest select vector onehot_legal accepts

    typedef logic [FLIT_W-1:0] flit_t;

    // True when exactly one bit of sel is set; narrower selects are zero-extended.
    function automatic logic onehot_legal(input logic [SEL_MAX_W-1:0] sel);
        int ones;
        ones = 0;
        for (int i = 0; i < SEL_MAX_W; i++) begin
            ones += int'(sel[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/nw_crossbar_oh_buffered_out_buf.sv
// Two-entry skid FIFO placed on each crossbar output.
module nw_crossbar_oh_buffered_out_buf
    import nw_crossbar_oh_buffered_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  flit_t      push_data,
    input  logic       pop,
    output flit_t      head_data,
    output logic [1:0] count,
    output logic       valid
);

    flit_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    // Storage, pointers and occupancy; push and pop may coincide at count=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset because data_out must read '0 after reset;
            // with only two entries this is cheap, unlike a large memory.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign valid     = (count != 2'd0);

    // Occupancy invariants checked every cycle outside reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count <= 2'd2);
            assert (valid == (count != 2'd0));
            assert (!(push && (count == 2'd2)));
        end
    end

endmodule

// File: rtl/nw_crossbar_oh_buffered.sv
// One-hot crossbar with a 2-entry skid buffer and sticky select-error flag per output.
module nw_crossbar_oh_buffered
    import nw_crossbar_oh_buffered_pkg::*;
#(
    parameter int n_in      = NW_PORTS,
    parameter int n_out     = NW_PORTS,
    parameter int buf_depth = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  flit_t [n_in-1:0]           data_in,
    input  logic  [n_out-1:0][n_in-1:0] select,
    input  logic  [n_out-1:0]          sel_valid,
    output logic  [n_out-1:0]          can_accept,
    output flit_t [n_out-1:0]          data_out,
    output logic  [n_out-1:0]          out_valid,
    input  logic  [n_out-1:0]          out_ready,
    output logic  [n_out-1:0]          err_sel,
    input  logic                       err_clr
);

    logic [n_out-1:0] push;
    logic [n_out-1:0] pop;
    logic [n_out-1:0] err_set;
    logic [1:0]       count [n_out];

    for (genvar o = 0; o < n_out; o++) begin : g_out
        flit_t mux_data;
        logic  legal;

        // AND-OR mux: only the selected input contributes to the tail write data.
        always_comb begin
            // NOTE: default first so no path leaves mux_data unassigned (no latch).
            mux_data = '0;
            for (int i = 0; i < n_in; i++) begin
                mux_data = mux_data | (data_in[i] & {FLIT_W{select[o][i]}});
            end
        end

        assign legal         = onehot_legal(SEL_MAX_W'(select[o]));
        assign can_accept[o] = (count[o] != 2'd2);
        assign push[o]       = sel_valid[o] & can_accept[o] & legal;
        assign err_set[o]    = sel_valid[o] & can_accept[o] & ~legal;
        assign pop[o]        = out_valid[o] & out_ready[o];

        nw_crossbar_oh_buffered_out_buf u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[o]),
            .push_data (mux_data),
            .pop       (pop[o]),
            .head_data (data_out[o]),
            .count     (count[o]),
            .valid     (out_valid[o])
        );
    end

    // Sticky error flags: a new illegal select wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= '0;
        end else begin
            err_sel <= err_set | (err_clr ? '0 : err_sel);
        end
    end

    // Only the two-entry buffer is implemented.
    always_ff @(posedge clk) begin
        assert (buf_depth == 2);
    end

endmodule

// File: doc/nw_crossbar_oh_buffered.md
Name: NW_crossbar_oh_buffered

Overview:
Parametrised successor to the router's one-hot crossbar. Supports independent input and output counts (n_in x n_out) and adds a 2-entry skid buffer on every output with a valid/ready handshake. It also detects illegal (non-one-hot) select codes and reports them through sticky per-output error flags. It sits between switch allocation and the output-port link registers, so a stalled downstream link no longer forces a combinational path back into the allocator.

Parameters:
n_in, 5, number of crossbar inputs (router input ports)
n_out, 5, number of crossbar outputs (router output ports)
buf_depth, 2, entries per output buffer; only 2 is supported; the value is checked by an assertion

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
data_in  input  n_in x flit_t  flit presented on each input port
select  input  n_out x n_in  select[o][i]=1 routes input i to output o; one-hot per output
sel_valid  input  n_out  request to push the selected flit into output o this cycle
can_accept  output  n_out  output o buffer has a free entry; a function of registered state only
data_out  output  n_out x flit_t  head flit of output o buffer
out_valid  output  n_out  data_out[o] is valid
out_ready  input  n_out  downstream accepts data_out[o] this cycle
err_sel  output  n_out  sticky: an illegal select was seen on output o
err_clr  input  1  synchronous clear of all err_sel bits

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low, on rst_n. Everything below is per output o; outputs are fully independent.
- Reset values: count=0, out_valid=0, data_out='0, storage entries='0, err_sel=0, can_accept=1.
- Legal select: select[o] has exactly one bit set.
- push = sel_valid[o] & can_accept[o] & legal select.
- pop = out_valid[o] & out_ready[o].
- can_accept[o] = (count<2). It has no combinational dependence on out_ready or sel_valid.
- Mux: push writes data_in[i] for the single set bit i into the tail entry.
- Latency: a flit pushed into an empty buffer at cycle t appears at data_out with out_valid=1 at cycle t+1.
- FIFO order is preserved. data_out is always the head entry and is held stable while out_valid=1 and out_ready=0.
- count transitions:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged. Possible only at count=1, because push cannot occur at count=2.
  - count=0 with out_ready high: no pop.
- With count=2, can_accept=0. Any sel_valid is ignored: no push and no error.
- Illegal select (zero bits or more than one bit set) while sel_valid[o] & can_accept[o]:
  - no push;
  - err_sel[o] is set next cycle;
  - the flit is dropped (the upstream allocator is at fault).
- An illegal select while sel_valid[o]=0 is ignored.
- err_clr=1 clears every err_sel bit next cycle. If a set and a clear occur in the same cycle, the set wins.
- Reset asserted mid-operation: all buffered flits are discarded immediately (asynchronous). The first push is accepted on the first clock edge after release.
- Empty-slot contents are don't-care internally. data_out still shows the head entry, so it equals '0 only after reset.
- Verification assertions:
  - count <= 2;
  - out_valid == (count != 0);
  - no push while can_accept=0.

Decomposition:
- Shared package (existing NW package): flit_t and FLIT_W live there. Add a localparam for the default router port count and a one-hot check function (onehot_legal).
- Sub-module: NW_xbar_out_buf, a 2-entry skid FIFO with a flit_t data port, push/pop, and count/valid outputs. It is instantiated n_out times inside a generate loop.
- The per-output mux is a for-loop OR-reduction gated by select bits.

Test Plan:
- Reset/idle: hold rst_n=0 then release, with all sel_valid=0 -> out_valid=0, can_accept=all-1, err_sel=0, data_out='0.
- Basic route: data_in[3]=0x5A, select[1]=5'b01000, sel_valid[1]=1 at cycle t, out_ready=1 -> data_out[1]=0x5A with out_valid[1]=1 at t+1 only. Other outputs remain idle.
- Backpressure: push 0x11, 0x22, 0x33 on consecutive cycles into output 0 with out_ready[0]=0 -> can_accept[0]=0 after the 2nd push. 0x33 is not accepted. Raising out_ready[0] yields 0x11 then 0x22; can_accept[0] returns to 1 the cycle after the first pop.
- Simultaneous push/pop: count=1 (head 0xA0), push 0xB0 with out_ready=1 -> next cycle data_out=0xB0 and count stays 1.
- Illegal select: select[2]=5'b00110 with sel_valid[2]=1 -> no push and err_sel[2]=1 next cycle. Then err_clr=1 with a second illegal select in the same cycle -> err_sel[2] stays 1. err_clr alone then clears it.
- Broadcast/all-to-all: each output o selects input (o+1)%5 with distinct data, all in one cycle -> every output shows the correct flit at t+1. Assert rst_n=0 mid-stream -> out_valid drops to 0 immediately.
